// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan: N:1 channel selector with a registered output and a
// valid/ready output handshake. Manual mode picks the channel from sel;
// scan mode walks the channels round-robin, DWELL accepted beats each.
//
// Optional feature macro: MUX_CH_MASK_EN
//   defined   -> ch_mask port present; scan skips masked channels and
//                manual mode refuses to load a masked channel.
//   undefined -> no ch_mask port; every channel is enabled.
//
// Handshake: a beat is transferred on a rising clk edge where out_vld and
// out_rdy are both high. While out_vld is high and out_rdy is low, out,
// out_ch and out_vld hold stable regardless of en, mode or sel.
module mux_n_1_scan #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 1,
   parameter int DWELL = 1,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*WIDTH-1:0] din,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  out_rdy,
   output logic [WIDTH-1:0]      out,
   output logic                  out_vld,
   output logic [SEL_W-1:0]      out_ch
`ifdef MUX_CH_MASK_EN
   ,
   input  logic [N_CH-1:0]       ch_mask
`endif
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(N_CH - 1);
   localparam logic [DW_W-1:0]  LAST_DWELL = DW_W'(DWELL - 1);

   logic [SEL_W-1:0] ptr;       // scan position (registered)
   logic [DW_W-1:0]  dwell_cnt; // beats already taken from ptr's channel
   logic [SEL_W-1:0] eff_ptr;   // channel scan will actually sample now
   logic [SEL_W-1:0] adv_ptr;   // channel scan moves to after the dwell ends
   logic             ch_ok;     // the chosen channel may be loaded
   logic [SEL_W-1:0] cur;
   logic [WIDTH-1:0] cur_data;
   logic             ld;

`ifdef MUX_CH_MASK_EN
   // Resolve masked scan positions: eff_ptr is the first enabled channel at
   // or above ptr (wrapping), adv_ptr the next enabled one above eff_ptr.
   // A sel outside 0..N_CH-1 has no mask bit and is treated as enabled.
   always_comb begin
      int idx;
      logic sel_ok;
      eff_ptr = ptr;
      adv_ptr = ptr;
      sel_ok  = 1'b1;
      idx     = 0;
      // Descending offsets so the smallest matching offset wins.
      for (int off = N_CH - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= N_CH) idx = idx - N_CH;
         if (ch_mask[SEL_W'(idx)]) eff_ptr = SEL_W'(idx);
      end
      for (int off = N_CH; off >= 1; off--) begin
         idx = int'(eff_ptr) + off;
         if (idx >= N_CH) idx = idx - N_CH;
         if (ch_mask[SEL_W'(idx)]) adv_ptr = SEL_W'(idx);
      end
      for (int k = 0; k < N_CH; k++) begin
         if (sel == SEL_W'(k)) sel_ok = ch_mask[k];
      end
      ch_ok = mode ? (|ch_mask) : sel_ok;
   end
`else
   // All channels enabled: scan samples ptr and steps to the next index.
   always_comb begin
      eff_ptr = ptr;
      adv_ptr = (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
      ch_ok   = 1'b1;
   end
`endif

   // Channel choice, data select and load decision. An out-of-range manual
   // select matches no channel and so yields a zero sample.
   always_comb begin
      cur      = mode ? eff_ptr : sel;
      cur_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (cur == SEL_W'(k)) cur_data = din[k*WIDTH +: WIDTH];
      end
      ld = en && ch_ok && (!out_vld || out_rdy);
   end

   // Output register: load a new beat, retire an accepted one, or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out     <= '0;
         out_vld <= 1'b0;
         out_ch  <= '0;
      end else if (ld) begin
         out     <= cur_data;
         out_ch  <= cur;
         out_vld <= 1'b1;
      end else if (out_vld && out_rdy) begin
         out_vld <= 1'b0;
      end
   end

   // Scan position: parked at ch0 with a fresh dwell in manual mode, frozen
   // without a load, and advanced once DWELL beats of a channel have loaded.
   always_ff @(posedge clk) begin
      if (rst || !mode) begin
         ptr       <= '0;
         dwell_cnt <= '0;
      end else if (ld) begin
         if (dwell_cnt == LAST_DWELL) begin
            dwell_cnt <= '0;
            ptr       <= adv_ptr;
         end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
            ptr       <= eff_ptr;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_1_scan.sv
// tb_mux_n_1_scan: directed bench for mux_n_1_scan with N_CH=4, WIDTH=8,
// DWELL=2 and channel data A0,B1,C2,D3. Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point.
module tb_mux_n_1_scan;

   localparam int N_CH  = 4;
   localparam int WIDTH = 8;
   localparam int DWELL = 2;
   localparam int SEL_W = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CH*WIDTH-1:0] din;
   logic                  en;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic                  out_rdy;
   logic [WIDTH-1:0]      out;
   logic                  out_vld;
   logic [SEL_W-1:0]      out_ch;
`ifdef MUX_CH_MASK_EN
   logic [N_CH-1:0]       ch_mask;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] ch_data [N_CH] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
   logic [SEL_W-1:0] exp_q [$];

   mux_n_1_scan #(.N_CH(N_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .en      (en),
      .mode    (mode),
      .sel     (sel),
      .out_rdy (out_rdy),
      .out     (out),
      .out_vld (out_vld),
      .out_ch  (out_ch)
`ifdef MUX_CH_MASK_EN
      ,
      .ch_mask (ch_mask)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input string tag, input int ch);
      check({tag, ".vld"}, 32'(out_vld), 32'd1);
      check({tag, ".ch"},  32'(out_ch),  32'(ch));
      check({tag, ".out"}, 32'(out),     32'(ch_data[ch]));
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".vld"}, 32'(out_vld), 32'd0);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      en      = 1'b0;
      mode    = 1'b0;
      sel     = '0;
      out_rdy = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      din     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      rst     = 1'b1;
      en      = 1'b0;
      mode    = 1'b0;
      sel     = '0;
      out_rdy = 1'b0;
`ifdef MUX_CH_MASK_EN
      ch_mask = 4'hF;
`endif
      step();
      step();
      check("rst.out", 32'(out),     32'h0);
      check("rst.vld", 32'(out_vld), 32'h0);
      check("rst.ch",  32'(out_ch),  32'h0);

      // Manual select, one cycle latency
      rst     = 1'b0;
      en      = 1'b1;
      sel     = 2'd2;
      out_rdy = 1'b1;
      step();
      check_beat("man2", 2);
      sel = 2'd3;
      step();
      check_beat("man3", 3);

      // Stalled beat ignores sel/mode changes
      out_rdy = 1'b0;
      sel     = 2'd0;
      mode    = 1'b1;
      step();
      check_beat("hold_sel", 3);
      mode    = 1'b0;
      out_rdy = 1'b1;
      step();
      check_beat("man0", 0);

      // Scan from manual: starts at ch0 with full dwell, wraps 3 -> 0
      mode = 1'b1;
      exp_q = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
      while (exp_q.size() > 0) begin
         step();
         check_beat("scan", int'(exp_q.pop_front()));
      end

      // Backpressure at the first ch1 beat
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      step();
      check_beat("bp_pre0", 0);
      step();
      check_beat("bp_pre0b", 0);
      step();
      check_beat("bp_ch1", 1);
      out_rdy = 1'b0;
      repeat (3) begin
         step();
         check_beat("bp_hold", 1);
      end
      out_rdy = 1'b1;
      step();
      check_beat("bp_dwell", 1);
      step();
      check_beat("bp_next", 2);

      // Stop with a stalled beat pending, then resume at the held ptr
      en      = 1'b0;
      out_rdy = 1'b0;
      step();
      check_beat("stop_hold", 2);
      step();
      check_beat("stop_hold2", 2);
      out_rdy = 1'b1;
      step();
      check_idle("stop_drain");
      step();
      check_idle("stop_idle");
      en = 1'b1;
      step();
      check_beat("resume", 2);
      step();
      check_beat("resume_next", 3);

      // Reset in the middle of a stalled ch2 beat
      do_reset();
      mode = 1'b1;
      en   = 1'b1;
      repeat (5) step();
      check_beat("pre_rst", 2);
      out_rdy = 1'b0;
      rst     = 1'b1;
      step();
      check("mid_rst.out", 32'(out),     32'h0);
      check("mid_rst.vld", 32'(out_vld), 32'h0);
      check("mid_rst.ch",  32'(out_ch),  32'h0);
      rst     = 1'b0;
      out_rdy = 1'b1;
      step();
      check_beat("post_rst", 0);
      step();
      check_beat("post_rst2", 0);
      step();
      check_beat("post_rst3", 1);

`ifdef MUX_CH_MASK_EN
      // Masked scan skips ch0 and ch2; empty mask stops loading
      do_reset();
      ch_mask = 4'b1010;
      mode    = 1'b1;
      en      = 1'b1;
      exp_q = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
      while (exp_q.size() > 0) begin
         step();
         check_beat("mask_scan", int'(exp_q.pop_front()));
      end
      ch_mask = '0;
      step();
      check_idle("mask_empty");
      step();
      check_idle("mask_empty2");
      ch_mask = 4'hF;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
